// File: rtl/bus_fifo_v2_pkg.sv
// Shared types and width helpers for the lane-packed bus FIFO.
// The lane-vector macro keeps the packed [lanes][width] layout identical everywhere it is used.
`ifndef BUS_FIFO_LANE_VEC
`define BUS_FIFO_LANE_VEC(L, W) logic [(L)-1:0][(W)-1:0]
`endif

package bus_fifo_pkg;

  localparam int unsigned LANES_DEF = 6;
  localparam int unsigned WIDTH_DEF = 32;

  typedef `BUS_FIFO_LANE_VEC(LANES_DEF, WIDTH_DEF) lane_vec_t;

  function automatic int unsigned cnt_w(input int unsigned cap);
    return $clog2(cap + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bus_fifo_v2_if.sv
// Producer/consumer handshake bundle for bus_fifo_v2, plus occupancy and threshold signals.
// slave is the FIFO side, master is whoever drives and drains it.
interface bus_fifo_v2_if
  import bus_fifo_pkg::*;
#(
  parameter int unsigned LANES = 6,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 5
);
  logic                            in_valid;
  logic                            in_ready;
  `BUS_FIFO_LANE_VEC(LANES, WIDTH) in_data;
  logic                            out_valid;
  logic                            out_ready;
  `BUS_FIFO_LANE_VEC(LANES, WIDTH) out_data;
  logic [CW-1:0]                   af_th;
  logic [CW-1:0]                   count;
  logic                            almost_full;
  logic                            almost_empty;

  modport slave (
    input  in_valid, in_data, out_ready, af_th,
    output in_ready, out_valid, out_data, count, almost_full, almost_empty
  );

  modport master (
    output in_valid, in_data, out_ready, af_th,
    input  in_ready, out_valid, out_data, count, almost_full, almost_empty
  );
endinterface

// File: rtl/bus_fifo_v2_ram.sv
// Entry storage for bus_fifo_v2: one synchronous write port, one asynchronous read port.
// The array is deliberately left unreset; validity is tracked by the controller.
module bus_fifo_ram
  import bus_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 192
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ptr_w(DEPTH)-1:0]  waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [ptr_w(DEPTH)-1:0]  raddr,
  output logic [DW-1:0]            rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/bus_fifo_v2.sv
// Lane-packed valid/ready FIFO with optional output register, flush, occupancy count
// and almost-full/almost-empty flags. Pointers wrap by compare so DEPTH need not be a power of two.
module bus_fifo_v2
  import bus_fifo_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LANES   = 6,
  parameter int unsigned OUT_REG = 0,
  parameter int unsigned AE_TH   = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          flush,
  bus_fifo_v2_if.slave bus
);
  localparam int unsigned CAP = DEPTH + OUT_REG;
  localparam int unsigned CW  = cnt_w(CAP);
  localparam int unsigned AW  = ptr_w(DEPTH);
  localparam int unsigned DW  = LANES * WIDTH;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] head, tail;
  logic [CW-1:0] st_cnt, count;
  logic          full, push, pop, wr_en, rd_adv;
  logic [DW-1:0] rd_data;

  assign full          = (count == CW'(CAP));
  assign bus.in_ready  = !full && !flush;
  assign bus.out_valid = (count != '0) && !flush;
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  assign bus.count        = count;
  assign bus.almost_full  = (count >= bus.af_th);
  assign bus.almost_empty = (32'(count) <= AE_TH);

  bus_fifo_ram #(.DEPTH(DEPTH), .DW(DW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (tail),
    .wdata (bus.in_data),
    .raddr (head),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head   <= '0;
      tail   <= '0;
      st_cnt <= '0;
    end else begin
      if (wr_en)  tail <= (tail == LAST) ? '0 : tail + 1'b1;
      if (rd_adv) head <= (head == LAST) ? '0 : head + 1'b1;
      st_cnt <= st_cnt + CW'(wr_en) - CW'(rd_adv);
    end
  end

  if (OUT_REG == 0) begin : g_fwft
    assign wr_en  = push;
    assign rd_adv = pop;
    assign count  = st_cnt;
    // Gate the raw array read so an empty FIFO (including just after reset) shows zero.
    assign bus.out_data = (st_cnt != '0) ? rd_data : '0;
  end else begin : g_oreg
    logic          ov, oreg_free, load, push_direct;
    logic [DW-1:0] oreg;

    // Storage is only ever non-empty while ov is set, so a direct push never bypasses older data.
    assign oreg_free   = !ov || pop;
    assign load        = oreg_free && (st_cnt != '0);
    assign push_direct = push && (st_cnt == '0) && oreg_free;
    assign wr_en       = push && !push_direct;
    assign rd_adv      = load;
    assign count       = st_cnt + CW'(ov);
    assign bus.out_data = oreg;

    always_ff @(posedge clk) begin
      if (rst) begin
        ov   <= 1'b0;
        oreg <= '0;
      end else if (flush) begin
        ov <= 1'b0;
      end else if (oreg_free) begin
        ov <= load || push_direct;
        if (load)             oreg <= rd_data;
        else if (push_direct) oreg <= bus.in_data;
      end
    end
  end
endmodule

// File: tb/tb_bus_fifo_v2.sv
// Directed bench for bus_fifo_v2: three configurations driven from one sequence,
// each with a queue scoreboard filled on accepted pushes and drained on pops.
module tb_bus_fifo_v2;
  import bus_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush_a, flush_b, flush_c;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bus_fifo_v2_if #(.LANES(6), .WIDTH(32), .CW(5)) ifa ();
  bus_fifo_v2_if #(.LANES(6), .WIDTH(32), .CW(3)) ifb ();
  bus_fifo_v2_if #(.LANES(6), .WIDTH(32), .CW(3)) ifc ();

  bus_fifo_v2 #(.DEPTH(16), .WIDTH(32), .LANES(6), .OUT_REG(0), .AE_TH(2)) dut_a (
    .clk(clk), .rst(rst), .flush(flush_a), .bus(ifa));
  bus_fifo_v2 #(.DEPTH(5), .WIDTH(32), .LANES(6), .OUT_REG(0), .AE_TH(2)) dut_b (
    .clk(clk), .rst(rst), .flush(flush_b), .bus(ifb));
  bus_fifo_v2 #(.DEPTH(4), .WIDTH(32), .LANES(6), .OUT_REG(1), .AE_TH(2)) dut_c (
    .clk(clk), .rst(rst), .flush(flush_c), .bus(ifc));

  `define CHK(tag, obs, exp) begin \
    n_tests++; \
    assert ((obs) === (exp)) else begin \
      n_fail++; \
      $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
    end \
  end

  lane_vec_t q_a[$], q_b[$], q_c[$];
  logic      acc_a, acc_b, acc_c, pop_a, pop_b, pop_c, stall_c;
  lane_vec_t held_c;

  function automatic lane_vec_t mk(input int v);
    lane_vec_t r;
    for (int l = 0; l < 6; l++) r[l] = 32'(v * 16 + l);
    return r;
  endfunction

  function automatic lane_vec_t all_a5();
    lane_vec_t r;
    for (int l = 0; l < 6; l++) r[l] = 32'h0000_00A5;
    return r;
  endfunction

  task automatic underflow(input string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s_underflow: observed pop expected no pop (scoreboard empty)", tag);
  endtask

  // Evaluate handshakes just before the edge, advance one cycle, return at the falling edge.
  task automatic tick();
    lane_vec_t e;
    #1;
    acc_a = ifa.in_valid && ifa.in_ready;  pop_a = ifa.out_valid && ifa.out_ready;
    acc_b = ifb.in_valid && ifb.in_ready;  pop_b = ifb.out_valid && ifb.out_ready;
    acc_c = ifc.in_valid && ifc.in_ready;  pop_c = ifc.out_valid && ifc.out_ready;
    stall_c = ifc.out_valid && !ifc.out_ready && !flush_c && !rst;
    held_c  = ifc.out_data;
    if (pop_a) begin
      if (q_a.size() == 0) underflow("a");
      else begin e = q_a.pop_front(); `CHK("a_order", ifa.out_data, e) end
    end
    if (pop_b) begin
      if (q_b.size() == 0) underflow("b");
      else begin e = q_b.pop_front(); `CHK("b_order", ifb.out_data, e) end
    end
    if (pop_c) begin
      if (q_c.size() == 0) underflow("c");
      else begin e = q_c.pop_front(); `CHK("c_order", ifc.out_data, e) end
    end
    if (acc_a) q_a.push_back(ifa.in_data);
    if (acc_b) q_b.push_back(ifb.in_data);
    if (acc_c) q_c.push_back(ifc.in_data);
    @(posedge clk);
    @(negedge clk);
    if (stall_c) `CHK("c_stable", ifc.out_data, held_c)
  endtask

  initial begin
    int drained;
    int sent;

    rst = 1'b1; flush_a = 1'b0; flush_b = 1'b0; flush_c = 1'b0;
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b0; ifa.in_data = '0; ifa.af_th = 5'd12;
    ifb.in_valid = 1'b0; ifb.out_ready = 1'b0; ifb.in_data = '0; ifb.af_th = 3'd5;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b0; ifc.in_data = '0; ifc.af_th = 3'd5;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    `CHK("rst_in_ready", ifa.in_ready, 1'b1)
    `CHK("rst_out_valid", ifa.out_valid, 1'b0)
    `CHK("rst_count", ifa.count, 5'd0)
    `CHK("rst_af", ifa.almost_full, 1'b0)
    `CHK("rst_ae", ifa.almost_empty, 1'b1)
    `CHK("rst_out_data_a", ifa.out_data, lane_vec_t'(0))
    `CHK("rst_out_data_c", ifc.out_data, lane_vec_t'(0))

    // Fill A to full with no consumer; watch the flags track count
    for (int i = 0; i < 16; i++) begin
      ifa.in_valid = 1'b1;
      ifa.in_data  = mk(i);
      `CHK("a_fill_ready", ifa.in_ready, 1'b1)
      `CHK("a_fill_af", ifa.almost_full, (i >= 12))
      `CHK("a_fill_ae", ifa.almost_empty, (i <= 2))
      tick();
    end
    ifa.in_valid = 1'b0;
    `CHK("a_full_count", ifa.count, 5'd16)
    `CHK("a_full_ready", ifa.in_ready, 1'b0)
    ifa.af_th = 5'd17;
    #1 `CHK("a_af_above_cap", ifa.almost_full, 1'b0)
    ifa.af_th = 5'd16;
    #1 `CHK("a_af_at_cap", ifa.almost_full, 1'b1)
    ifa.af_th = 5'd12;

    // Full with push and pop offered together: only the pop happens
    ifa.in_valid = 1'b1; ifa.in_data = mk(99); ifa.out_ready = 1'b1;
    tick();
    ifa.in_valid = 1'b0;
    `CHK("a_fullpop_count", ifa.count, 5'd15)
    `CHK("a_fullpop_ready", ifa.in_ready, 1'b1)
    drained = 0;
    for (int k = 0; k < 40 && ifa.out_valid; k++) begin
      tick();
      drained++;
    end
    `CHK("a_drained", drained, 15)
    `CHK("a_empty_valid", ifa.out_valid, 1'b0)
    `CHK("a_empty_count", ifa.count, 5'd0)
    ifa.out_ready = 1'b0;
    ifa.af_th = 5'd0;
    #1 `CHK("a_af_zero", ifa.almost_full, 1'b1)
    ifa.af_th = 5'd12;

    // B: push and pop every cycle across several pointer wraps
    ifb.in_valid = 1'b1; ifb.out_ready = 1'b1;
    for (int k = 0; k < 23; k++) begin
      ifb.in_data = mk(500 + k);
      tick();
      `CHK("b_stream_count", ifb.count, 3'd1)
    end
    ifb.in_valid = 1'b0;
    tick();
    `CHK("b_end_count", ifb.count, 3'd0)
    ifb.out_ready = 1'b0;

    // C: output register adds one entry of capacity
    for (int k = 0; k < 5; k++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = mk(700 + k);
      `CHK("c_fill_ready", ifc.in_ready, 1'b1)
      tick();
    end
    ifc.in_valid = 1'b0;
    `CHK("c_full_count", ifc.count, 3'd5)
    `CHK("c_full_ready", ifc.in_ready, 1'b0)
    `CHK("c_head_data", ifc.out_data, mk(700))

    sent = 0;
    for (int k = 0; k < 300 && sent < 30; k++) begin
      ifc.in_valid  = 1'b1;
      ifc.in_data   = mk(800 + sent);
      ifc.out_ready = 1'($urandom_range(0, 1));
      tick();
      if (acc_c) sent++;
    end
    ifc.in_valid = 1'b0;
    `CHK("c_sent", sent, 30)
    ifc.out_ready = 1'b1;
    for (int k = 0; k < 20 && ifc.out_valid; k++) tick();
    `CHK("c_drain_count", ifc.count, 3'd0)
    ifc.out_ready = 1'b0;
    ifc.in_valid = 1'b1; ifc.in_data = mk(900);
    tick();
    ifc.in_valid = 1'b0;
    `CHK("c_latency_valid", ifc.out_valid, 1'b1)
    `CHK("c_latency_data", ifc.out_data, mk(900))
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    `CHK("c_last_count", ifc.count, 3'd0)

    // A: flush mid-stream discards held entries
    for (int k = 0; k < 7; k++) begin
      ifa.in_valid = 1'b1;
      ifa.in_data  = mk(300 + k);
      tick();
    end
    `CHK("a_pre_flush_count", ifa.count, 5'd7)
    flush_a = 1'b1; ifa.in_valid = 1'b1; ifa.in_data = mk(55);
    #1;
    `CHK("a_flush_ready", ifa.in_ready, 1'b0)
    `CHK("a_flush_valid", ifa.out_valid, 1'b0)
    tick();
    q_a.delete();
    flush_a = 1'b0;
    ifa.in_valid = 1'b0;
    `CHK("a_post_flush_count", ifa.count, 5'd0)
    ifa.in_valid = 1'b1; ifa.in_data = all_a5();
    tick();
    ifa.in_valid = 1'b0;
    `CHK("a_a5_valid", ifa.out_valid, 1'b1)
    `CHK("a_a5_data", ifa.out_data, all_a5())
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    `CHK("a_final_count", ifa.count, 5'd0)

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  `undef CHK
endmodule
